// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: qualifies PLL lock, holds all domain resets, then
// releases them in index order, gated on each domain's ready handshake.
module rst_seq_ctrl #(
    parameter int NDOM      = 3,
    parameter int LOCK_FILT = 8,
    parameter int HOLD_CYC  = 16,
    parameter int GAP_CYC   = 4,
    parameter int TMO_CYC   = 64,
    parameter int CW        = 8
) (
    input  logic            clk,
    input  logic            grst,
    input  logic            pll_lock,
    input  logic            soft_req,
    input  logic [NDOM-1:0] dom_ready,
    output logic [NDOM-1:0] rst_out,
    output logic            seq_done,
    output logic            busy,
    output logic            lock_lost,
    output logic [NDOM-1:0] tmo_err
);

    localparam int IW = (NDOM > 1) ? $clog2(NDOM) : 1;
    localparam logic [CW-1:0] LF_C   = CW'(LOCK_FILT);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYC);
    localparam logic [CW-1:0] GAP_C  = CW'(GAP_CYC);
    localparam logic [CW-1:0] TMO_C  = CW'(TMO_CYC);
    localparam logic [IW-1:0] LAST   = IW'(NDOM - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        REL,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic [CW-1:0]   lcnt_q, lcnt_d;
    logic [CW-1:0]   hcnt_q, hcnt_d;
    logic [CW-1:0]   gcnt_q, gcnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NDOM-1:0] rst_q, rst_d;
    logic            lost_q, lost_d;
    logic [NDOM-1:0] tmo_q, tmo_d;

    logic            lock_s;
    logic [CW-1:0]   lcnt_inc, hcnt_inc, gcnt_inc;
    logic [IW-1:0]   idx_nx;
    logic            rdy_adv, tmo_adv;

    assign lock_s = sync_q[1];

    // Saturating increments so no counter ever wraps
    assign lcnt_inc = (lcnt_q == '1) ? lcnt_q : lcnt_q + 1'b1;
    assign hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + 1'b1;
    assign gcnt_inc = (gcnt_q == '1) ? gcnt_q : gcnt_q + 1'b1;
    assign idx_nx   = idx_q + 1'b1;

    assign rdy_adv = dom_ready[idx_q] && (gcnt_inc >= GAP_C);
    assign tmo_adv = (gcnt_inc == TMO_C);

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        hcnt_d  = hcnt_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        lost_d  = lost_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    lcnt_d = '0;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc == LF_C) begin
                        state_d = HOLD;
                        hcnt_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (lock_s) begin
                    hcnt_d = hcnt_inc;
                    if (hcnt_inc == HOLD_C) begin
                        state_d  = REL;
                        idx_d    = '0;
                        rst_d[0] = 1'b0;
                        gcnt_d   = '0;
                    end
                end
            end
            REL: begin
                if (lock_s) begin
                    gcnt_d = gcnt_inc;
                    if (rdy_adv || tmo_adv) begin
                        if (!rdy_adv) tmo_d[idx_q] = 1'b1;
                        if (idx_q == LAST) begin
                            state_d = RUN;
                        end else begin
                            idx_d         = idx_nx;
                            rst_d[idx_nx] = 1'b0;
                            gcnt_d        = '0;
                        end
                    end
                end
            end
            RUN: begin
                if (lock_s && soft_req) begin
                    rst_d   = '1;
                    state_d = HOLD;
                    hcnt_d  = '0;
                end
            end
        endcase
        // Lock loss overrides every other transition outside WAIT_LOCK
        if (!lock_s && state_q != WAIT_LOCK) begin
            rst_d   = '1;
            lost_d  = 1'b1;
            state_d = WAIT_LOCK;
            lcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            state_q <= WAIT_LOCK;
            sync_q  <= '0;
            lcnt_q  <= '0;
            hcnt_q  <= '0;
            gcnt_q  <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            lost_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], pll_lock};
            lcnt_q  <= lcnt_d;
            hcnt_q  <= hcnt_d;
            gcnt_q  <= gcnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            lost_q  <= lost_d;
            tmo_q   <= tmo_d;
        end
    end

    assign rst_out   = rst_q;
    assign seq_done  = (state_q == RUN);
    assign busy      = (state_q != RUN);
    assign lock_lost = lost_q;
    assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: an edge-timeline model predicts every
// output change; a monitor pops and compares whenever the outputs move.
module tb_rst_seq_ctrl;

    localparam int NDOM  = 3;
    localparam int LF    = 8;
    localparam int HOLD  = 16;
    localparam int GAP   = 4;
    localparam int TMO   = 64;
    localparam int NEVER = 1000000;

    logic            clk = 1'b0;
    logic            grst = 1'b1;
    logic            pll_lock = 1'b0;
    logic            soft_req = 1'b0;
    logic [NDOM-1:0] dom_ready = '0;
    logic [NDOM-1:0] rst_out;
    logic            seq_done;
    logic            busy;
    logic            lock_lost;
    logic [NDOM-1:0] tmo_err;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NDOM(NDOM), .LOCK_FILT(LF), .HOLD_CYC(HOLD),
        .GAP_CYC(GAP), .TMO_CYC(TMO), .CW(8)
    ) dut (
        .clk(clk), .grst(grst), .pll_lock(pll_lock),
        .soft_req(soft_req), .dom_ready(dom_ready),
        .rst_out(rst_out), .seq_done(seq_done), .busy(busy),
        .lock_lost(lock_lost), .tmo_err(tmo_err)
    );

    typedef struct {
        int              edge_n;
        logic [NDOM-1:0] rst;
        logic            done;
        logic            busy;
        logic            lost;
        logic [NDOM-1:0] tmo;
    } snap_t;

    int    n_assert = 0;
    int    n_fail = 0;
    int    edge_n = 0;
    bit    mon_en = 0;
    snap_t exp_q[$];
    snap_t cur;
    snap_t prev;
    snap_t act;
    snap_t ex;

    int    probe_cnt = 0;
    int    probe_seen = 0;
    int    probe_kind = 0;
    snap_t probe_exp;
    event  probe_ev;

    // stimulus schedule
    int    rdy_edge[NDOM];
    int    lo_a[2];
    int    lo_b[2];
    int    soft_e[2];
    int    rel_e[NDOM+1];
    int    rel1[NDOM+1];

    function automatic snap_t rst_snap();
        snap_t s;
        s.edge_n = 0;
        s.rst = '1;
        s.done = 1'b0;
        s.busy = 1'b1;
        s.lost = 1'b0;
        s.tmo = '0;
        return s;
    endfunction

    function automatic snap_t sample();
        snap_t s;
        s.edge_n = edge_n;
        s.rst = rst_out;
        s.done = seq_done;
        s.busy = busy;
        s.lost = lock_lost;
        s.tmo = tmo_err;
        return s;
    endfunction

    function automatic bit same_out(snap_t a, snap_t b);
        return (a.rst === b.rst) && (a.done === b.done) &&
               (a.busy === b.busy) && (a.lost === b.lost) &&
               (a.tmo === b.tmo);
    endfunction

    function automatic bit lock_at(int n);
        if (n <= 0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (n >= lo_a[k] && n <= lo_b[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void push_ev(int e);
        snap_t s;
        s = cur;
        s.edge_n = e;
        exp_q.push_back(s);
    endfunction

    function automatic void push_reset(int e, bit lost);
        cur.rst = '1;
        cur.done = 1'b0;
        cur.busy = 1'b1;
        if (lost) cur.lost = 1'b1;
        push_ev(e);
    endfunction

    // Release timeline from the edge domain 0 is freed; events at or
    // after cutoff are pre-empted and not produced.
    function automatic void model_seq(int rel0, int cutoff, bit dry);
        int e, rd, to, adv;
        for (int k = 0; k <= NDOM; k++) rel_e[k] = NEVER;
        if (rel0 >= cutoff) return;
        e = rel0;
        rel_e[0] = rel0;
        cur.rst[0] = 1'b0;
        if (!dry) push_ev(rel0);
        for (int i = 0; i < NDOM; i++) begin
            rd = (e + GAP > rdy_edge[i]) ? e + GAP : rdy_edge[i];
            to = e + TMO;
            adv = (rd <= to) ? rd : to;
            if (adv >= cutoff) return;
            if (rd > to) cur.tmo[i] = 1'b1;
            if (i < NDOM - 1) begin
                cur.rst[i+1] = 1'b0;
            end else begin
                cur.done = 1'b1;
                cur.busy = 1'b0;
            end
            rel_e[i+1] = adv;
            if (!dry) push_ev(adv);
            e = adv;
        end
    endfunction

    initial begin : monitor
        forever begin
            @(posedge clk or probe_ev);
            if (probe_cnt != probe_seen) begin
                probe_seen = probe_cnt;
                act = sample();
                n_assert++;
                if (probe_kind == 0) begin
                    if (!same_out(act, probe_exp)) begin
                        n_fail++;
                        $display("FAIL async_state got rst=%b done=%b busy=%b lost=%b tmo=%b want rst=%b done=%b busy=%b lost=%b tmo=%b",
                            act.rst, act.done, act.busy, act.lost, act.tmo,
                            probe_exp.rst, probe_exp.done, probe_exp.busy,
                            probe_exp.lost, probe_exp.tmo);
                    end
                    prev = act;
                end else begin
                    if (exp_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL missing_events got %0d pending want 0 (next at edge %0d)",
                            exp_q.size(), exp_q[0].edge_n);
                    end
                    exp_q.delete();
                end
            end else begin
                #1;
                if (mon_en) begin
                    act = sample();
                    if (!same_out(act, prev)) begin
                        prev = act;
                        n_assert++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_change edge=%0d got rst=%b done=%b busy=%b lost=%b tmo=%b want no change",
                                act.edge_n, act.rst, act.done, act.busy, act.lost, act.tmo);
                        end else begin
                            ex = exp_q.pop_front();
                            if (!same_out(act, ex) || act.edge_n != ex.edge_n) begin
                                n_fail++;
                                $display("FAIL event got edge=%0d rst=%b done=%b busy=%b lost=%b tmo=%b want edge=%0d rst=%b done=%b busy=%b lost=%b tmo=%b",
                                    act.edge_n, act.rst, act.done, act.busy, act.lost, act.tmo,
                                    ex.edge_n, ex.rst, ex.done, ex.busy, ex.lost, ex.tmo);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic probe(input int k, input snap_t e);
        probe_kind = k;
        probe_exp = e;
        probe_cnt++;
        -> probe_ev;
        #1;
    endtask

    task automatic do_reset();
        mon_en = 0;
        grst = 1'b1;
        pll_lock = 1'b0;
        soft_req = 1'b0;
        dom_ready = '0;
        repeat (2) @(negedge clk);
        probe(0, rst_snap());
        @(negedge clk);
        grst = 1'b0;
        edge_n = 0;
        mon_en = 1;
    endtask

    task automatic run_edges(input int last);
        for (int n = 1; n <= last; n++) begin
            pll_lock = lock_at(n);
            soft_req = (n == soft_e[0]) || (n == soft_e[1]);
            for (int i = 0; i < NDOM; i++) dom_ready[i] = (n >= rdy_edge[i]);
            @(posedge clk);
            edge_n = n;
            @(negedge clk);
        end
    endtask

    // kind: 0 plain, 1 soft reset in RUN, 2 lock loss anywhere,
    // 3 lock loss with soft_req in RUN, 4 grst mid-REL, 5 lock loss in REL idx 1
    task automatic run_scn(input int kind, input bit glitch, input int g, input int len);
        int q, rel0, hs, done1, s, le, d, gr, last;
        snap_t sv;
        for (int k = 0; k < 2; k++) begin
            lo_a[k] = NEVER;
            lo_b[k] = -1;
            soft_e[k] = NEVER;
        end
        if (glitch) begin
            lo_a[0] = g;
            lo_b[0] = g + len - 1;
        end
        q = (glitch ? g + len - 1 : 0) + 2 + LF;
        rel0 = q + HOLD;
        hs = $urandom_range(q + 1, rel0);
        soft_e[0] = hs;
        cur = rst_snap();
        sv = cur;
        model_seq(rel0, NEVER, 1'b1);
        rel1 = rel_e;
        done1 = rel_e[NDOM];
        cur = sv;
        last = 0;
        case (kind)
            1: begin
                s = done1 + $urandom_range(1, 8);
                soft_e[1] = s;
                model_seq(rel0, NEVER, 1'b0);
                push_reset(s, 1'b0);
                model_seq(s + HOLD, NEVER, 1'b0);
                last = rel_e[NDOM] + 6;
            end
            2, 3, 5: begin
                if (kind == 2) le = $urandom_range(q + 1, done1 + 5);
                else if (kind == 3) le = done1 + $urandom_range(1, 6);
                else le = $urandom_range(rel1[1] + 1, rel1[2]);
                if (kind == 3) soft_e[1] = le;
                d = $urandom_range(1, 6);
                lo_a[1] = le - 2;
                lo_b[1] = le - 2 + d - 1;
                model_seq(rel0, le, 1'b0);
                push_reset(le, 1'b1);
                model_seq(le + d - 1 + LF + HOLD, NEVER, 1'b0);
                last = rel_e[NDOM] + 6;
            end
            4: begin
                gr = $urandom_range(rel1[0] + 1, done1);
                model_seq(rel0, gr, 1'b0);
                last = gr - 1;
            end
            default: begin
                model_seq(rel0, NEVER, 1'b0);
                last = done1 + 6;
            end
        endcase
        do_reset();
        run_edges(last);
        mon_en = 0;
        if (kind == 4) begin
            #1 grst = 1'b1;
            #1 probe(0, rst_snap());
        end
        probe(1, rst_snap());
    endtask

    initial begin : stim
        int kind;
        for (int i = 0; i < NDOM; i++) rdy_edge[i] = 0;
        run_scn(0, 1'b0, 0, 0);
        run_scn(0, 1'b1, 6, 1);
        rdy_edge[1] = NEVER;
        run_scn(0, 1'b0, 0, 0);
        rdy_edge[1] = 0;
        run_scn(1, 1'b0, 0, 0);
        run_scn(5, 1'b0, 0, 0);
        run_scn(3, 1'b0, 0, 0);
        run_scn(4, 1'b0, 0, 0);
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NDOM; i++)
                rdy_edge[i] = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(0, 160);
            kind = $urandom_range(0, 5);
            run_scn(kind, $urandom_range(0, 1) == 1,
                    $urandom_range(1, 7), $urandom_range(1, 3));
        end
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
